// File: rtl/clock_divider_if.sv
// clock_divider_if: run control, ratio handshake and divided-clock outputs of clock_divider.
interface clock_divider_if #(parameter int DIV_W = 8);
  logic en;
  logic [DIV_W-1:0] div_ratio;
  logic div_load;
  logic div_ack;
  logic busy;
  logic tick;
  logic ckout;
  logic ckoutb;
  modport master (output en, div_ratio, div_load, input div_ack, busy, tick, ckout, ckoutb);
  modport slave (input en, div_ratio, div_load, output div_ack, busy, tick, ckout, ckoutb);
endinterface

// File: rtl/clock_divider.sv
// clock_divider: programmable integer divider with glitch-free ratio updates at period boundaries.
module clock_divider #(
  parameter int DIV_W = 8,
  parameter int DIV_INIT = 4
) (
  input logic clk,
  input logic rst,
  clock_divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, HIGH = 2'b01, LOW = 2'b10} state_t;
  localparam logic [DIV_W-1:0] INIT = (DIV_INIT < 2) ? DIV_W'(2) : DIV_W'(DIV_INIT);
  function automatic logic [DIV_W-1:0] clamp(input logic [DIV_W-1:0] n);
    return (n < DIV_W'(2)) ? DIV_W'(2) : n;
  endfunction
  state_t state, state_n;
  logic [DIV_W-1:0] ratio, ratio_n, pend, pend_n, cnt, cnt_n, nr;
  logic pend_v, pend_v_n, tick_r, tick_n, ack_r, ack_n;
  logic boundary, apply, start;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ratio <= INIT;
      pend <= '0;
      pend_v <= 1'b0;
      cnt <= '0;
      tick_r <= 1'b0;
      ack_r <= 1'b0;
    end else begin
      state <= state_n;
      ratio <= ratio_n;
      pend <= pend_n;
      pend_v <= pend_v_n;
      cnt <= cnt_n;
      tick_r <= tick_n;
      ack_r <= ack_n;
    end
  end
  // IDLE counts as a boundary, so a pending ratio lands there without waiting for en
  always_comb begin
    boundary = (state == IDLE) || (state == LOW && cnt == '0);
    apply = boundary && pend_v;
    start = boundary && bus.en;
    nr = apply ? clamp(pend) : ratio;
    ratio_n = nr;
    ack_n = apply;
    tick_n = start;
    pend_n = bus.div_load ? bus.div_ratio : pend;
    pend_v_n = bus.div_load | (pend_v & ~apply);
    state_n = boundary ? (bus.en ? HIGH : IDLE) : (cnt != '0) ? state : LOW;
    cnt_n = start ? (nr - 1'b1) >> 1
          : (state == HIGH && cnt == '0) ? (ratio >> 1) - 1'b1
          : (cnt == '0) ? '0 : cnt - 1'b1;
  end
  always_comb begin
    bus.ckout = state[0];
    bus.ckoutb = ~state[0];
    bus.tick = tick_r;
    bus.div_ack = ack_r;
    bus.busy = pend_v;
  end
endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: vector table, directed corner sequences and random run against a period-position model.
module tb_clock_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  clock_divider_if #(.DIV_W(8)) bus();
  clock_divider #(.DIV_W(8), .DIV_INIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int passed = 0;
  int ack_cnt = 0;
  bit m_run, m_pv, m_tick, m_ack;
  int m_pos, m_n, m_pend;
  typedef struct {
    logic rst, en, load;
    logic [7:0] ratio;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[17];
  function automatic int clampn(input int n);
    return n < 2 ? 2 : n;
  endfunction
  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got {ck,ckb,tick,ack,busy}=%b expected %b", name, $time, act, exp);
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask
  function automatic logic [4:0] outs();
    return {bus.ckout, bus.ckoutb, bus.tick, bus.div_ack, bus.busy};
  endfunction
  function automatic logic [4:0] mexp();
    logic ck;
    ck = m_run && (m_pos < (m_n + 1) / 2);
    return {ck, ~ck, m_tick, m_ack, m_pv};
  endfunction
  // model tracks position within the period rather than phase counters
  task automatic model_edge();
    bit bnd, app;
    if (rst) begin
      m_run = 0; m_pos = 0; m_n = 4; m_pv = 0; m_tick = 0; m_ack = 0;
    end else begin
      bnd = !m_run || (m_pos == m_n - 1);
      app = bnd && m_pv;
      m_ack = app;
      if (app) m_n = clampn(m_pend);
      m_pv = bus.div_load || (m_pv && !app);
      if (bus.div_load) m_pend = int'(bus.div_ratio);
      if (bnd) begin
        m_run = bus.en;
        m_pos = 0;
        m_tick = bus.en;
      end else begin
        m_pos++;
        m_tick = 0;
      end
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", outs(), mexp());
    if (bus.div_ack) ack_cnt++;
  endtask
  task automatic run_until_tick(input string name);
    int k = 0;
    do begin cycle(); k++; end while (!bus.tick && k < 600);
    chk_i({name, "_tick"}, int'(bus.tick), 1);
  endtask
  task automatic measure(input string name, output int h, output int l);
    int k = 0;
    h = 1; l = 0;
    cycle();
    while (!bus.tick && k < 600) begin
      if (bus.ckout) h++; else l++;
      cycle();
      k++;
    end
    chk_i({name, "_tmo"}, int'(bus.tick), 1);
  endtask
  task automatic do_ratio(input string name, input int r, input int eh, input int el);
    int h, l;
    bus.div_load = 1; bus.div_ratio = 8'(r);
    cycle();
    bus.div_load = 0;
    run_until_tick(name);
    chk_i({name, "_ack"}, int'(bus.div_ack), 1);
    measure(name, h, l);
    chk_i({name, "_h"}, h, eh);
    chk_i({name, "_l"}, l, el);
  endtask
  initial begin
    int h, l, t, a0;
    bus.en = 0; bus.div_load = 0; bus.div_ratio = 0;
    vecs[0] = '{1, 0, 0, 0, 5'b01000};
    vecs[1] = '{1, 0, 0, 0, 5'b01000};
    vecs[2] = '{1, 0, 0, 0, 5'b01000};
    vecs[3] = '{0, 1, 0, 0, 5'b10100};
    vecs[4] = '{0, 1, 0, 0, 5'b10000};
    vecs[5] = '{0, 1, 0, 0, 5'b01000};
    vecs[6] = '{0, 1, 0, 0, 5'b01000};
    vecs[7] = '{0, 1, 0, 0, 5'b10100};
    vecs[8] = '{0, 1, 1, 5, 5'b10001};
    vecs[9] = '{0, 1, 0, 0, 5'b01001};
    vecs[10] = '{0, 1, 0, 0, 5'b01001};
    vecs[11] = '{0, 1, 0, 0, 5'b10110};
    vecs[12] = '{0, 1, 0, 0, 5'b10000};
    vecs[13] = '{0, 1, 0, 0, 5'b10000};
    vecs[14] = '{0, 1, 0, 0, 5'b01000};
    vecs[15] = '{0, 1, 0, 0, 5'b01000};
    vecs[16] = '{0, 1, 0, 0, 5'b10100};
    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; bus.en = vecs[i].en;
      bus.div_load = vecs[i].load; bus.div_ratio = vecs[i].ratio;
      cycle();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    bus.div_load = 0;
    a0 = ack_cnt;
    do_ratio("clamp0", 0, 1, 1);
    do_ratio("clamp1", 1, 1, 1);
    chk_i("clamp_acks", ack_cnt - a0, 2);
    do_ratio("n4", 4, 2, 2);
    cycle();
    bus.div_load = 1; bus.div_ratio = 6;
    cycle();
    bus.div_load = 0;
    chk_i("mid_busy3", int'(bus.busy), 1);
    cycle();
    chk_i("mid_busy4", int'(bus.busy), 1);
    cycle();
    chk("mid_boundary", outs(), 5'b10110);
    measure("mid6", h, l);
    chk_i("mid6_h", h, 3);
    chk_i("mid6_l", l, 3);
    do_ratio("n8", 8, 4, 4);
    bus.div_load = 1; bus.div_ratio = 3;
    cycle();
    bus.div_ratio = 2;
    cycle();
    bus.div_load = 0;
    a0 = ack_cnt;
    run_until_tick("ovw");
    measure("ovw", h, l);
    chk_i("ovw_h", h, 1);
    chk_i("ovw_l", l, 1);
    chk_i("ovw_acks", ack_cnt - a0, 1);
    do_ratio("n6", 6, 3, 3);
    bus.en = 0;
    h = 0; l = 0; t = 0;
    repeat (10) begin
      cycle();
      if (bus.ckout) h++; else l++;
      if (bus.tick) t++;
    end
    chk_i("stop_h", h, 2);
    chk_i("stop_l", l, 8);
    chk_i("stop_ticks", t, 0);
    bus.en = 1;
    do_ratio("n8b", 8, 4, 4);
    cycle();
    bus.div_load = 1; bus.div_ratio = 3;
    cycle();
    bus.div_load = 0;
    a0 = ack_cnt;
    rst = 1;
    cycle();
    chk("rst_mid", outs(), 5'b01000);
    rst = 0;
    run_until_tick("rst_run");
    measure("rst_init", h, l);
    chk_i("rst_init_h", h, 2);
    chk_i("rst_init_l", l, 2);
    chk_i("rst_no_ack", ack_cnt - a0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.en = ($urandom_range(0, 9) != 0);
      bus.div_load = ($urandom_range(0, 11) == 0);
      bus.div_ratio = 8'($urandom_range(0, 12));
      cycle();
    end
    rst = 0; bus.div_load = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Programmable integer clock divider, directly downstream of the clock stimulus generator. Consumes its ckout as the single clock.
- Produces a divided clock, ckout/ckoutb, plus a one-cycle period-start tick for downstream samplers and stimulus blocks.
- Divide ratio is reprogrammable at run time through a load/ack handshake. New ratios are applied glitch-free, only at output period boundaries.

Parameters:
- DIV_W, 8, width of the divide-ratio bus.
- DIV_INIT, 4, ratio in effect after reset. Clamped per the ratio rule below.

Ports:
- clk  input  1  clock input (driven by upstream clock generator ckout)
- rst  input  1  reset, synchronous, active-high
- en  input  1  divider run enable, sampled on clk rising edge
- div_ratio  input  DIV_W  requested divide ratio N (unsigned)
- div_load  input  1  one-cycle strobe: capture div_ratio into the pending register
- div_ack  output  1  one-cycle pulse: pending ratio became active
- busy  output  1  high while a captured ratio is pending (not yet applied)
- tick  output  1  one-cycle pulse on the first clk cycle of each output period
- ckout  output  1  divided clock, registered
- ckoutb  output  1  always the exact inverse of ckout

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All state updates on the clk rising edge.
- Reset values (rst=1 at an edge):
  - state=IDLE, ckout=0, ckoutb=1, tick=0, div_ack=0, busy=0.
  - active ratio = clamp(DIV_INIT); counter=0; pending register cleared.
  - Reset mid-period aborts immediately; no period completion.
- Ratio rule:
  - Neff = 2 if N<2, otherwise Neff = N.
  - High phase H = ceil(Neff/2) cycles; low phase L = floor(Neff/2) cycles. Period = Neff clk cycles.
  - Example: N=5 gives H=3, L=2.
- States: IDLE, HIGH, LOW. A down-counter counts the remaining cycles in the current phase.
  - IDLE: ckout=0. If en=1 is sampled, the next cycle enters HIGH with ckout=1 and tick=1. Latency from en to the first ckout rise is 1 clk.
  - HIGH: ckout=1 for H cycles, then LOW.
  - LOW: ckout=0 for L cycles. On the last LOW cycle (the boundary):
    - en=1: enter HIGH, tick=1.
    - en=0: enter IDLE.
- en deasserted mid-period: the current period completes fully before IDLE. No runt pulses.
- en reasserted before the boundary: the divider continues without a gap.
- Ratio handshake:
  - div_load=1 captures div_ratio into pending and sets busy=1 on the next cycle.
  - Pending is applied at the first period boundary strictly after capture. In that same cycle the new period starts with the new H/L, div_ack=1 for one cycle, and busy returns to 0.
  - In IDLE, a pending ratio is applied on the cycle after capture (div_ack pulses), without waiting for en.
  - div_load while busy: pending is overwritten by the newest value; one div_ack is issued for the last value only.
  - div_load in the boundary cycle itself: the value is captured as pending and applies at the following boundary. The boundary in progress uses the previously active/pending ratio.
- tick and div_ack are never asserted during reset. Each is high for exactly one cycle per event.
- ckout is a flop output. There is no combinational path from any input to ckout/ckoutb.

Test Plan:
- Reset defaults: rst=1 for 3 cycles, then en=1 with DIV_INIT=4 -> ckout=0/ckoutb=1 during reset. After en: ckout sequence 1,1,0,0 repeating; tick every 4th cycle, aligned with each ckout rise.
- Odd and clamped ratios: load N=5 -> pattern 1,1,1,0,0. Load N=0 and load N=1 -> each gives pattern 1,0. div_ack occurs once per load, at a boundary.
- Mid-period reprogram: running N=4, div_load N=6 in cycle 2 of HIGH -> current period stays 4 cycles; busy=1 until the boundary; next period is 1,1,1,0,0,0 with div_ack coincident with its tick.
- Overwrite while busy: running N=8, load 3 then load 2 before the boundary -> single div_ack; next period uses N=2.
- Graceful stop: en=0 in the first HIGH cycle at N=6 -> remaining 2 HIGH + 3 LOW cycles complete, then IDLE with ckout=0 and no further ticks.
- Reset mid-operation: rst=1 during HIGH at N=8 with a pending load -> next cycle ckout=0, busy=0, no div_ack; active ratio reverts to DIV_INIT.
